// File: rtl/rat_io_responder.sv
// Port-mapped I/O responder for the RAT CPU: output latches, receive FIFO,
// interrupt line, and an interval timer built only when RAT_IO_TIMER_EN is defined.
module rat_io_responder #(
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] port_id,
    input  logic [7:0] out_port,
    input  logic       io_strb,
    output logic [7:0] in_port,
    output logic       interrupt,
    input  logic [7:0] switches,
    output logic [7:0] leds,
    output logic [7:0] sseg,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready
);

    localparam int         PW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [4:0] DEPTH5 = 5'(FIFO_DEPTH);

    localparam logic [7:0] P_SW     = 8'h20;
    localparam logic [7:0] P_LEDS   = 8'h40;
    localparam logic [7:0] P_SSEG   = 8'h41;
    localparam logic [7:0] P_RL_LO  = 8'h80;
    localparam logic [7:0] P_RL_HI  = 8'h81;
    localparam logic [7:0] P_CTRL   = 8'h82;
    localparam logic [7:0] P_PEND   = 8'h83;
    localparam logic [7:0] P_FDATA  = 8'h90;
    localparam logic [7:0] P_FSTAT  = 8'h91;

    logic       wr_leds, wr_sseg, wr_ctrl, wr_ack, wr_stat;
    logic       wr_rl_lo, wr_rl_hi;

    logic [7:0] sync_q [SYNC_STAGES];
    logic [7:0] sync_d [SYNC_STAGES];
    logic [7:0] leds_q, leds_d;
    logic [7:0] sseg_q, sseg_d;
    logic [2:0] ctrl_q, ctrl_d;
    logic       interrupt_q, interrupt_d;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [4:0]    count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          empty, full, push, pop;

    logic          tmr_pend;
    logic [7:0]    rl_lo_rd, rl_hi_rd;

    always_comb begin
        wr_leds  = io_strb && (port_id == P_LEDS);
        wr_sseg  = io_strb && (port_id == P_SSEG);
        wr_rl_lo = io_strb && (port_id == P_RL_LO);
        wr_rl_hi = io_strb && (port_id == P_RL_HI);
        wr_ctrl  = io_strb && (port_id == P_CTRL);
        wr_ack   = io_strb && (port_id == P_PEND);
        wr_stat  = io_strb && (port_id == P_FSTAT);
    end

    always_comb begin
        sync_d[0] = switches;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_comb begin
        leds_d = wr_leds ? out_port : leds_q;
        sseg_d = wr_sseg ? out_port : sseg_q;
        ctrl_d = ctrl_q;
        if (wr_ctrl) begin
`ifdef RAT_IO_TIMER_EN
            ctrl_d = out_port[2:0];
`else
            ctrl_d = {out_port[2], 2'b00};
`endif
        end
    end

`ifdef RAT_IO_TIMER_EN
    logic [15:0] reload_q, reload_d;
    logic [15:0] cnt_q, cnt_d;
    logic        tmr_pend_q, tmr_pend_d;

    always_comb begin
        reload_d   = reload_q;
        cnt_d      = cnt_q;
        tmr_pend_d = tmr_pend_q;
        if (wr_rl_lo) reload_d[7:0]  = out_port;
        if (wr_rl_hi) reload_d[15:8] = out_port;
        if (wr_ack && out_port[0]) tmr_pend_d = 1'b0;
        // An enable edge restarts the period; a set on the ack edge wins.
        if (wr_ctrl && out_port[0] && !ctrl_q[0]) begin
            cnt_d = reload_q;
        end else if (ctrl_q[0] && (reload_q != 16'd0)) begin
            if (cnt_q == 16'd0) begin
                tmr_pend_d = 1'b1;
                cnt_d      = reload_q;
            end else begin
                cnt_d = cnt_q - 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reload_q   <= '0;
            cnt_q      <= '0;
            tmr_pend_q <= 1'b0;
        end else begin
            reload_q   <= reload_d;
            cnt_q      <= cnt_d;
            tmr_pend_q <= tmr_pend_d;
        end
    end

    assign tmr_pend = tmr_pend_q;
    assign rl_lo_rd = reload_q[7:0];
    assign rl_hi_rd = reload_q[15:8];
`else
    logic unused_rl_wr;

    assign unused_rl_wr = wr_rl_lo | wr_rl_hi;
    assign tmr_pend     = 1'b0;
    assign rl_lo_rd     = 8'h00;
    assign rl_hi_rd     = 8'h00;
`endif

    always_comb begin
        empty = (count_q == 5'd0);
        full  = (count_q == DEPTH5);
        push  = rx_valid && !full;
        pop   = wr_stat && !empty;

        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = rx_data;

        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 5'd1;
            2'b01:   count_d = count_q - 5'd1;
            default: count_d = count_q;
        endcase

        overflow_d = overflow_q;
        if (wr_stat && out_port[7]) overflow_d = 1'b0;
        if (rx_valid && full)       overflow_d = 1'b1;
    end

    always_comb begin
        interrupt_d = (tmr_pend & ctrl_q[1]) | (!empty & ctrl_q[2]);
    end

    always_comb begin
        in_port = 8'h00;
        case (port_id)
            P_SW:    in_port = sync_q[SYNC_STAGES-1];
            P_LEDS:  in_port = leds_q;
            P_SSEG:  in_port = sseg_q;
            P_RL_LO: in_port = rl_lo_rd;
            P_RL_HI: in_port = rl_hi_rd;
            P_CTRL:  in_port = {5'b0, ctrl_q};
            P_PEND:  in_port = {6'b0, !empty, tmr_pend};
            P_FDATA: in_port = empty ? 8'h00 : mem_q[rd_ptr_q];
            P_FSTAT: in_port = {overflow_q, full, empty, count_q};
            default: in_port = 8'h00;
        endcase
    end

    // Storage needs no reset; the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            leds_q      <= '0;
            sseg_q      <= '0;
            ctrl_q      <= '0;
            interrupt_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            leds_q      <= leds_d;
            sseg_q      <= sseg_d;
            ctrl_q      <= ctrl_d;
            interrupt_q <= interrupt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
        end
    end

    assign leds      = leds_q;
    assign sseg      = sseg_q;
    assign interrupt = interrupt_q;
    assign rx_ready  = !full;

endmodule

// File: doc/rat_io_responder.md
# rat_io_responder

Port-mapped I/O responder for the pipelined RAT CPU: decodes the CPU's `port_id`/`out_port`/`io_strb` output bus and drives the CPU `in_port` read bus.
- Holds output latches (LEDs, seven-segment) and a programmable 16-bit interval timer.
- Buffers an external receive byte stream in a FIFO.
- Drives the CPU's `input_interrupt` line.

Sits between the CPU top level and board peripherals.

## Interface
Parameters
- `FIFO_DEPTH`, 8, receive FIFO entries; power of two, 2–16.
- `SYNC_STAGES`, 2, flip-flops in the switch input synchronizer.

Ports
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `port_id`  in  8  CPU port address.
- `out_port`  in  8  CPU write data.
- `io_strb`  in  1  CPU write strobe; one cycle per OUT instruction.
- `in_port`  out  8  read data returned to the CPU.
- `interrupt`  out  1  level interrupt to the CPU `input_interrupt`.
- `switches`  in  8  asynchronous board switches.
- `leds`  out  8  LED latch.
- `sseg`  out  8  seven-segment latch.
- `rx_data`  in  8  receive byte from the external source.
- `rx_valid`  in  1  receive byte valid.
- `rx_ready`  out  1  FIFO can accept a byte; equals not-full.

## Operation
Port map. W = OUT effect when `io_strb` is high and `port_id` matches. R = `in_port` value.
- 0x20: R returns synchronized switches. W has no effect.
- 0x40: W latches `leds`. R returns `leds`.
- 0x41: W latches `sseg`. R returns `sseg`.
- 0x80: W sets reload[7:0]. R returns reload[7:0].
- 0x81: W sets reload[15:8]. R returns reload[15:8].
- 0x82 control: bit0 `tmr_en`, bit1 `tmr_ie`, bit2 `rx_ie`; R returns {5'b0, ctrl}.
- 0x83 pending/ack:
  - R returns {6'b0, rx_pend, tmr_pend}.
  - W with bit0 = 1 clears `tmr_pend`.
- 0x90: R returns the FIFO head byte, or 0 when the FIFO is empty.
- 0x91 status:
  - R returns {overflow, full, empty, count[4:0]}.
  - W pops one entry; a pop on an empty FIFO is ignored.
  - W with bit7 = 1 also clears `overflow`.
- All other addresses: R returns 0x00; W is ignored.

Behaviour
- `in_port` is purely combinational from `port_id` and registered state. A read has no side effects.
- Timer:
  - A 16-bit down counter.
  - On a `tmr_en` 0→1 write, the counter loads reload.
  - While enabled and reload ≠ 0, the counter decrements each cycle.
  - At count 0 it sets `tmr_pend` and reloads, giving a period of reload+1 cycles.
  - reload = 0 means the timer never counts.
  - Writing reload while the timer runs takes effect at the next reload.
- FIFO:
  - A byte is pushed when `rx_valid && rx_ready`.
  - `rx_valid` while full sets `overflow` and drops the byte, even if a pop occurs in the same cycle.
  - A push and a pop in the same cycle when neither full nor empty leaves count unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
- `rx_pend` = !empty (combinational).
- `interrupt` = (`tmr_pend` & `tmr_ie`) | (`rx_pend` & `rx_ie`), registered.
- Interrupt line behaviour:
  - The line stays high until its source is cleared by a `tmr_pend` ack or by draining the FIFO.
  - Clearing an enable bit masks the output but keeps the pending bit.

## Timing
- Reset values:
  - Outputs: `leds` = 0, `sseg` = 0, `in_port` = 0 (with `port_id` = 0), `interrupt` = 0, `rx_ready` = 1.
  - State: ctrl = 0, reload = 0, counter = 0, pending = 0, FIFO empty, overflow = 0, synchronizer = 0.
- Reset during operation discards FIFO contents and pending interrupts in the same edge.
- Writes take effect at the `clk` edge where `io_strb` is high; the new value is visible on R from the next cycle.
- `interrupt` rises one cycle after the pending-and-enabled condition becomes true, and falls one cycle after it clears.
- Switch reads reflect pin changes after `SYNC_STAGES` edges.
- `rx_ready` is low in the cycle after the push that fills the FIFO, and high in the cycle after the pop that frees a slot.

## Configuration
- `RAT_IO_TIMER_EN` defined: the timer, ports 0x80–0x82 timer bits, and `tmr_pend` are implemented.
- Not defined:
  - No timer logic is compiled.
  - Ports 0x80/0x81 read 0 and ignore writes.
  - Control bits 0–1 read 0.
  - `tmr_pend` = 0.
  - `interrupt` is driven only by `rx_pend & rx_ie`.

## Test plan
- Reset, then OUT 0x40 ← 0xA5 and OUT 0x41 ← 0x3C → `leds` = 0xA5 and `sseg` = 0x3C the next cycle; reading port 0x40 returns 0xA5; reading port 0x55 returns 0x00.
- Reload = 0x0004, OUT 0x82 ← 0x03 → `tmr_pend` sets every 5 cycles; `interrupt` is high one cycle later; OUT 0x83 ← 0x01 drops `interrupt` one cycle after the ack.
- Push 3 bytes 0x11, 0x22, 0x33 → reading 0x91 returns 0x03 and reading 0x90 returns 0x11; after OUT 0x91 (pop), reading 0x90 returns 0x22.
- Hold `rx_valid` for FIFO_DEPTH+2 bytes with no pops → `rx_ready` = 0 after 8 accepted bytes; reading 0x91 returns 0xC8; OUT 0x91 ← 0x80 clears overflow and pops one entry.
- With `rx_ie` = 1, push one byte → `interrupt` = 1; pop it → `interrupt` = 0 one cycle later.
- Assert `rst` with the FIFO holding 5 entries and the timer running → the next cycle shows the FIFO empty, `interrupt` = 0, and ctrl = 0.
